// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and scancode decoder.
package ps2_pkg;

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} dec_state_e;

  // Prefix and modifier scancodes (set 2)
  localparam logic [7:0] ScExt    = 8'hE0;
  localparam logic [7:0] ScBrk    = 8'hF0;
  localparam logic [7:0] ScLshift = 8'h12;
  localparam logic [7:0] ScRshift = 8'h59;
  localparam logic [7:0] ScCtrl   = 8'h14;

  // Extended arrow scancodes
  localparam logic [7:0] ScUp    = 8'h75;
  localparam logic [7:0] ScDown  = 8'h72;
  localparam logic [7:0] ScRight = 8'h74;
  localparam logic [7:0] ScLeft  = 8'h6B;

  // Output codes for arrows and control keys
  localparam logic [7:0] KeyUp    = 8'h80;
  localparam logic [7:0] KeyDown  = 8'h81;
  localparam logic [7:0] KeyRight = 8'h82;
  localparam logic [7:0] KeyLeft  = 8'h83;
  localparam logic [7:0] KeyBs    = 8'h08;
  localparam logic [7:0] KeyTab   = 8'h09;
  localparam logic [7:0] KeyEnter = 8'h0D;
  localparam logic [7:0] KeyEsc   = 8'h1B;
  localparam logic [7:0] KeySpace = 8'h20;

endpackage

// File: rtl/ps2_scancode_lut.sv
// US-layout scancode (set 2) to character translation; purely combinational.
module ps2_scancode_lut
  import ps2_pkg::*;
(
  input  logic [7:0] scancode,
  input  logic       shift,
  input  logic       ctrl,
  input  logic       ext,
  output logic [7:0] code,
  output logic       hit
);

  logic [15:0] lh;  // {unshifted, shifted}
  logic        tbl_hit;
  logic [7:0]  lo, hi;

  always_comb begin
    lh      = '0;
    tbl_hit = 1'b1;
    unique case (scancode)
      8'h1C: lh = "aA";  8'h32: lh = "bB";  8'h21: lh = "cC";  8'h23: lh = "dD";
      8'h24: lh = "eE";  8'h2B: lh = "fF";  8'h34: lh = "gG";  8'h33: lh = "hH";
      8'h43: lh = "iI";  8'h3B: lh = "jJ";  8'h42: lh = "kK";  8'h4B: lh = "lL";
      8'h3A: lh = "mM";  8'h31: lh = "nN";  8'h44: lh = "oO";  8'h4D: lh = "pP";
      8'h15: lh = "qQ";  8'h2D: lh = "rR";  8'h1B: lh = "sS";  8'h2C: lh = "tT";
      8'h3C: lh = "uU";  8'h2A: lh = "vV";  8'h1D: lh = "wW";  8'h22: lh = "xX";
      8'h35: lh = "yY";  8'h1A: lh = "zZ";
      8'h16: lh = "1!";  8'h1E: lh = "2@";  8'h26: lh = "3#";  8'h25: lh = "4$";
      8'h2E: lh = "5%";  8'h36: lh = "6^";  8'h3D: lh = "7&";  8'h3E: lh = "8*";
      8'h46: lh = "9(";  8'h45: lh = "0)";
      8'h0E: lh = "`~";  8'h4E: lh = "-_";  8'h55: lh = "=+";  8'h54: lh = "[{";
      8'h5B: lh = "]}";  8'h5D: lh = "\\|"; 8'h4C: lh = ";:";  8'h52: lh = "'\"";
      8'h41: lh = ",<";  8'h49: lh = ".>";  8'h4A: lh = "/?";
      8'h29: lh = {KeySpace, KeySpace};
      8'h66: lh = {KeyBs, KeyBs};
      8'h5A: lh = {KeyEnter, KeyEnter};
      8'h0D: lh = {KeyTab, KeyTab};
      8'h76: lh = {KeyEsc, KeyEsc};
      default: tbl_hit = 1'b0;
    endcase
  end

  assign lo = lh[15:8];
  assign hi = lh[7:0];

  always_comb begin
    code = '0;
    hit  = 1'b0;
    if (ext) begin
      hit = 1'b1;
      unique case (scancode)
        ScUp:    code = KeyUp;
        ScDown:  code = KeyDown;
        ScRight: code = KeyRight;
        ScLeft:  code = KeyLeft;
        default: hit = 1'b0;
      endcase
    end else if (tbl_hit) begin
      hit = 1'b1;
      // Ctrl folds letters onto 0x01..0x1A and overrides shift
      if (ctrl && lo >= "a" && lo <= "z") code = lo - 8'h60;
      else                                code = shift ? hi : lo;
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver, scancode decoder and output queue, all on px_clk.
// Build macro PS2_PARITY_CHECK_EN enables odd-parity checking of received frames.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       px_clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_data,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);

  // Synchronisers idle high, matching the bus idle state
  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic clk_s, data_s, clk_prev_q, fall;

  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_s;
    end
  end

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;

  // Receiver: shift_q holds {parity, data[7:0], start} once ten bits are in
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [9:0]      shift_q, shift_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            frame_ok;

`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = ~shift_q[0] & data_s & (^shift_q[9:1]);
`else
  logic unused_parity;
  assign unused_parity = shift_q[9];
  assign frame_ok      = ~shift_q[0] & data_s;
`endif

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tmr_d       = '0;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    if (fall) begin
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = '0;
        if (frame_ok) begin
          rx_valid_d = 1'b1;
          rx_byte_d  = shift_q[8:1];
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {data_s, shift_q[9:1]};
      end
    end else if (bit_cnt_q != '0) begin
      if (tmr_q == TmrW'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt_d   = '0;
        frame_err_d = 1'b1;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tmr_q       <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tmr_q       <= tmr_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;

  // Decoder: prefix FSM, modifier tracking and translation into push_q/push_code_q
  dec_state_e state_q, state_d;
  logic       lshift_q, lshift_d, rshift_q, rshift_d, ctrl_q, ctrl_d;
  logic       push_q, push_d;
  logic [7:0] push_code_q, push_code_d;
  logic       is_make, is_brk, is_ext, lut_hit;
  logic [7:0] lut_code;

  assign is_ext = (state_q == StExt) || (state_q == StExtBrk);

  ps2_scancode_lut u_lut (
    .scancode (rx_byte_q),
    .shift    (lshift_q | rshift_q),
    .ctrl     (ctrl_q),
    .ext      (is_ext),
    .code     (lut_code),
    .hit      (lut_hit)
  );

  always_comb begin
    state_d     = state_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    ctrl_d      = ctrl_q;
    push_d      = 1'b0;
    push_code_d = push_code_q;
    is_make     = 1'b0;
    is_brk      = 1'b0;
    if (rx_valid_q) begin
      unique case (state_q)
        StIdle: begin
          if (rx_byte_q == ScExt)      state_d = StExt;
          else if (rx_byte_q == ScBrk) state_d = StBrk;
          else                         is_make = 1'b1;
        end
        StExt: begin
          if (rx_byte_q == ScBrk) state_d = StExtBrk;
          else begin
            is_make = 1'b1;
            state_d = StIdle;
          end
        end
        default: begin
          is_brk  = 1'b1;
          state_d = StIdle;
        end
      endcase
    end
    if (is_make || is_brk) begin
      if (!is_ext && rx_byte_q == ScLshift)      lshift_d = is_make;
      else if (!is_ext && rx_byte_q == ScRshift) rshift_d = is_make;
      else if (rx_byte_q == ScCtrl)              ctrl_d   = is_make;
      else if (is_make && lut_hit) begin
        push_d      = 1'b1;
        push_code_d = lut_code;
      end
    end
  end

  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) begin
      state_q     <= StIdle;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      ctrl_q      <= 1'b0;
      push_q      <= 1'b0;
      push_code_q <= '0;
    end else begin
      state_q     <= state_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      ctrl_q      <= ctrl_d;
      push_q      <= push_d;
      push_code_q <= push_code_d;
    end
  end

  // Output queue; pointers carry an extra wrap bit to tell full from empty
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [PtrW:0] wr_ptr_q, rd_ptr_q;
  logic        full, pop, do_push, overflow_q;

  assign key_valid = (wr_ptr_q != rd_ptr_q);
  assign full      = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign pop       = key_valid & key_ready;
  assign do_push   = push_q & (~full | pop);
  assign key_data  = key_valid ? mem_q[rd_ptr_q[PtrW-1:0]] : 8'h00;
  assign overflow  = overflow_q;

  always_ff @(posedge px_clk) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= push_code_q;
  end

  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      overflow_q <= push_q & full & ~pop;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: directed vector table plus corner-case sequences.
module tb_ps2_keyboard;

  localparam int unsigned TO = 100;

  logic       px_clk = 1'b0;
  logic       clr = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_data;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       frame_err;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int ovf_cnt  = 0;

  ps2_keyboard #(
    .FIFO_DEPTH     (4),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .px_clk    (px_clk),
    .clr       (clr),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_data  (key_data),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 px_clk = ~px_clk;

  always @(negedge px_clk) begin
    if (frame_err) err_cnt++;
    if (overflow)  ovf_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // mode 0: plain, 1: check key_valid latency on the stop edge, 2: pop while the push lands
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_start,
                            input bit bad_stop, input int nbits, input int mode);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, bad_start};
    for (int i = 0; i < nbits; i++) begin
      @(negedge px_clk) ps2_data = bits[i];
      repeat (4) @(negedge px_clk);
      ps2_clk = 1'b0;
      if (i == 10 && mode == 1) begin
        repeat (4) @(posedge px_clk);
        #1 check("latency_not_yet", key_valid, 1'b0);
        @(posedge px_clk);
        #1 check("latency_valid", key_valid, 1'b1);
      end else if (i == 10 && mode == 2) begin
        repeat (4) @(posedge px_clk);
        @(negedge px_clk) key_ready = 1'b1;
        @(negedge px_clk) key_ready = 1'b0;
      end else begin
        repeat (8) @(negedge px_clk);
      end
      @(negedge px_clk) ps2_clk = 1'b1;
      repeat (8) @(negedge px_clk);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0, 11, 0);
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    @(negedge px_clk);
    check({name, "_valid"}, key_valid, 1'b1);
    check({name, "_data"}, key_data, exp);
    key_ready = 1'b1;
    @(negedge px_clk) key_ready = 1'b0;
  endtask

  typedef struct {
    logic [23:0] bytes;  // first byte in bits [7:0]
    int          n;
    bit          has;
    logic [7:0]  key;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input bit has, input logic [7:0] key);
    vec_t v;
    v.bytes = {b2, b1, b0};
    v.n     = n;
    v.has   = has;
    v.key   = key;
    return v;
  endfunction

  vec_t vecs[$];
  int   e0, o0;

  initial begin
    vecs.push_back(mk(1, 8'h12, 0, 0, 0, 0));            // lshift make
    vecs.push_back(mk(1, 8'h1C, 0, 0, 1, 8'h41));        // 'A'
    vecs.push_back(mk(2, 8'hF0, 8'h1C, 0, 0, 0));
    vecs.push_back(mk(2, 8'hF0, 8'h12, 0, 0, 0));
    vecs.push_back(mk(1, 8'h1C, 0, 0, 1, 8'h61));        // 'a' again
    vecs.push_back(mk(1, 8'h14, 0, 0, 0, 0));            // ctrl make
    vecs.push_back(mk(1, 8'h21, 0, 0, 1, 8'h03));        // ctrl+c
    vecs.push_back(mk(1, 8'h12, 0, 0, 0, 0));            // ctrl+shift
    vecs.push_back(mk(1, 8'h1A, 0, 0, 1, 8'h1A));        // ctrl+shift+z
    vecs.push_back(mk(2, 8'hF0, 8'h12, 0, 0, 0));
    vecs.push_back(mk(2, 8'hF0, 8'h14, 0, 0, 0));
    vecs.push_back(mk(2, 8'hE0, 8'h75, 0, 1, 8'h80));    // up
    vecs.push_back(mk(3, 8'hE0, 8'hF0, 8'h75, 0, 0));    // up break
    vecs.push_back(mk(2, 8'hE0, 8'h72, 0, 1, 8'h81));
    vecs.push_back(mk(2, 8'hE0, 8'h74, 0, 1, 8'h82));
    vecs.push_back(mk(2, 8'hE0, 8'h6B, 0, 1, 8'h83));
    vecs.push_back(mk(2, 8'hE0, 8'h14, 0, 0, 0));        // right ctrl
    vecs.push_back(mk(1, 8'h1C, 0, 0, 1, 8'h01));
    vecs.push_back(mk(3, 8'hE0, 8'hF0, 8'h14, 0, 0));
    vecs.push_back(mk(1, 8'h59, 0, 0, 0, 0));            // rshift
    vecs.push_back(mk(1, 8'h16, 0, 0, 1, 8'h21));        // '!'
    vecs.push_back(mk(1, 8'h4A, 0, 0, 1, 8'h3F));        // '?'
    vecs.push_back(mk(2, 8'hF0, 8'h59, 0, 0, 0));
    vecs.push_back(mk(1, 8'h4A, 0, 0, 1, 8'h2F));        // '/'
    vecs.push_back(mk(1, 8'h29, 0, 0, 1, 8'h20));
    vecs.push_back(mk(1, 8'h66, 0, 0, 1, 8'h08));
    vecs.push_back(mk(1, 8'h5A, 0, 0, 1, 8'h0D));
    vecs.push_back(mk(1, 8'h0D, 0, 0, 1, 8'h09));
    vecs.push_back(mk(1, 8'h76, 0, 0, 1, 8'h1B));
    vecs.push_back(mk(1, 8'h45, 0, 0, 1, 8'h30));        // '0'
    vecs.push_back(mk(1, 8'h07, 0, 0, 0, 0));            // unmapped (F12)

    // Reset state
    repeat (3) @(negedge px_clk);
    check("rst_valid", key_valid, 1'b0);
    check("rst_data", key_data, 8'h00);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    clr = 1'b0;
    repeat (3) @(negedge px_clk);

    // Single key with exact latency
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 11, 1);
    pop_expect("first_a", 8'h61);

    // Vector table
    e0 = err_cnt;
    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) send(vecs[i].bytes[8*k +: 8]);
      if (vecs[i].has) pop_expect($sformatf("vec%0d", i), vecs[i].key);
      @(negedge px_clk);
      check($sformatf("vec%0d_empty", i), key_valid, 1'b0);
    end
    check("table_no_frame_err", err_cnt - e0, 0);

    // Parity flip on 0x16
    e0 = err_cnt;
    send_frame(8'h16, 1'b1, 1'b0, 1'b0, 11, 0);
`ifdef PS2_PARITY_CHECK_EN
    check("parity_err", err_cnt - e0, 1);
    check("parity_no_entry", key_valid, 1'b0);
`else
    check("parity_ignored_err", err_cnt - e0, 0);
    pop_expect("parity_ignored", 8'h31);
`endif

    // Start and stop errors
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 11, 0);
    check("start_err", err_cnt - e0, 1);
    check("start_no_entry", key_valid, 1'b0);
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b0, 1'b1, 11, 0);
    check("stop_err", err_cnt - e0, 1);
    check("stop_no_entry", key_valid, 1'b0);

    // Overflow: five keys into a four-entry queue
    o0 = ovf_cnt;
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    check("hold_data", key_data, 8'h61);
    send(8'h24);
    check("overflow_once", ovf_cnt - o0, 1);
    check("hold_data_full", key_data, 8'h61);
    pop_expect("ovf0", 8'h61);
    pop_expect("ovf1", 8'h62);
    pop_expect("ovf2", 8'h63);
    pop_expect("ovf3", 8'h64);
    @(negedge px_clk);
    check("ovf_last_lost", key_valid, 1'b0);

    // Push and pop in the same cycle while full
    o0 = ovf_cnt;
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    send_frame(8'h24, 1'b0, 1'b0, 1'b0, 11, 2);
    check("full_pushpop_no_ovf", ovf_cnt - o0, 0);
    pop_expect("pp0", 8'h62);
    pop_expect("pp1", 8'h63);
    pop_expect("pp2", 8'h64);
    pop_expect("pp3", 8'h65);
    @(negedge px_clk);
    check("pp_empty", key_valid, 1'b0);

    // Timeout after five bits
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 5, 0);
    repeat (TO + 50) @(negedge px_clk);
    check("timeout_err_once", err_cnt - e0, 1);
    e0 = err_cnt;
    send(8'h1C);
    check("after_timeout_no_err", err_cnt - e0, 0);
    pop_expect("after_timeout", 8'h61);

    // Reset mid-frame discards the partial frame
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 4, 0);
    @(negedge px_clk) clr = 1'b1;
    @(negedge px_clk) clr = 1'b0;
    repeat (3) @(negedge px_clk);
    e0 = err_cnt;
    send(8'h1C);
    check("after_clr_no_err", err_cnt - e0, 0);
    pop_expect("after_clr", 8'h61);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
